// File: rtl/flash_code_avg.sv
// Block averager behind the flash ADC thermometer encoder: rounds the mean of 2^AVG_LOG2 codes
// and presents it on a one-entry valid/ready port. Define FLASH_MINMAX_EN to add block min/max outputs.
module flash_code_avg #(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [4:0] code_in,
    input  logic       gs_in,
    input  logic       acc_clr,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [4:0] avg_code,
    output logic       out_under,
    output logic       out_ovf
`ifdef FLASH_MINMAX_EN
    ,
    output logic [4:0] out_min,
    output logic [4:0] out_max
`endif
);

    localparam int unsigned N     = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = 5 + AVG_LOG2 + 1;
    localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned HALF  = N >> 1;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [SUM_W-1:0]   sum, sum_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               under, under_n;
    logic [4:0]         sample_c;
    logic [SUM_W-1:0]   rounded_c;
    logic [4:0]         avg_c;
    logic               load_c, drop_c, take_c;
`ifdef FLASH_MINMAX_EN
    logic [4:0]         trk_min, trk_min_n;
    logic [4:0]         trk_max, trk_max_n;
`endif

    // Under-range samples count as code 0
    assign sample_c  = gs_in ? code_in : 5'd0;
    assign rounded_c = sum + SUM_W'(HALF);
    assign avg_c     = 5'(rounded_c >> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            sum     <= '0;
            cnt     <= '0;
            under   <= 1'b0;
`ifdef FLASH_MINMAX_EN
            trk_min <= 5'd31;
            trk_max <= 5'd0;
`endif
        end else begin
            state   <= state_n;
            sum     <= sum_n;
            cnt     <= cnt_n;
            under   <= under_n;
`ifdef FLASH_MINMAX_EN
            trk_min <= trk_min_n;
            trk_max <= trk_max_n;
`endif
        end
    end

    // DONE restarts from an empty block, so a strobe in DONE becomes the first sample of the next one
    always_comb begin
        state_n   = COLLECT;
        sum_n     = sum;
        cnt_n     = cnt;
        under_n   = under;
`ifdef FLASH_MINMAX_EN
        trk_min_n = trk_min;
        trk_max_n = trk_max;
`endif
        if (state == DONE || acc_clr) begin
            sum_n     = '0;
            cnt_n     = '0;
            under_n   = 1'b0;
`ifdef FLASH_MINMAX_EN
            trk_min_n = 5'd31;
            trk_max_n = 5'd0;
`endif
        end
        if (!acc_clr && sample_en) begin
            sum_n   = sum_n + SUM_W'(sample_c);
            under_n = under_n | ~gs_in;
            if (cnt_n == CNT_W'(N - 1)) begin
                state_n = DONE;
            end
            cnt_n   = cnt_n + CNT_W'(1);
`ifdef FLASH_MINMAX_EN
            if (sample_c < trk_min_n) trk_min_n = sample_c;
            if (sample_c > trk_max_n) trk_max_n = sample_c;
`endif
        end
    end

    assign take_c = out_valid & out_ready;
    assign load_c = (state == DONE) & (~out_valid | out_ready);
    assign drop_c = (state == DONE) & out_valid & ~out_ready;

    // One-entry output register; a result arriving while the slot is blocked is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            avg_code  <= 5'd0;
            out_under <= 1'b0;
            out_ovf   <= 1'b0;
`ifdef FLASH_MINMAX_EN
            out_min   <= 5'd31;
            out_max   <= 5'd0;
`endif
        end else begin
            if (load_c) begin
                out_valid <= 1'b1;
                avg_code  <= avg_c;
                out_under <= under;
`ifdef FLASH_MINMAX_EN
                out_min   <= trk_min;
                out_max   <= trk_max;
`endif
            end else if (take_c) begin
                out_valid <= 1'b0;
            end
            if (drop_c) begin
                out_ovf <= 1'b1;
            end else if (take_c) begin
                out_ovf <= 1'b0;
            end
        end
    end

endmodule
